// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, credit-limited imem requests, prefetch FIFO and IF/ID register.
// Optional misaligned-redirect halting is enabled by defining FETCH_MISALIGN_CHK_EN.

module fetch_unit_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);
  // credits must never let a response land in a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_misalign
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  logic [31:0]   fetch_pc_r, rsp_pc_r;
  logic [CW-1:0] out_r, drop_r, cnt_r;
  logic [CW-1:0] out_nxt_s, cnt_nxt_s;
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [31:0]   fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]   fifo_data_r [FIFO_DEPTH];
  logic [31:0]   if_id_pc_r, if_id_instr_r;
  logic          if_id_valid_r;
  logic [31:0]   target_pc_s;
  logic          halted_s;
  logic          req_fire_s, rsp_take_s, rsp_live_s;
  logic          load_s, fifo_empty_s, push_s, pop_s, bypass_s;

  // redirect_pc low bits are masked; the misalign check inspects them separately
  assign target_pc_s    = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req_valid = !reset && !redirect && !halted_s &&
                          (({1'b0, out_r} + {1'b0, cnt_r}) < DEPTH_C);
  assign imem_req_addr  = fetch_pc_r;

  assign req_fire_s   = imem_req_valid && imem_req_ready;
  assign rsp_take_s   = imem_rsp_valid && (out_r != CNT_ZERO);
  assign rsp_live_s   = rsp_take_s && (drop_r == CNT_ZERO) && !redirect;
  assign load_s       = !stall || !if_id_valid_r;
  assign fifo_empty_s = (cnt_r == CNT_ZERO);
  assign pop_s        = load_s && !fifo_empty_s && !redirect;
  assign bypass_s     = load_s && fifo_empty_s && rsp_live_s;
  assign push_s       = rsp_live_s && !bypass_s;

  // next outstanding-request and FIFO occupancy counts
  always_comb begin
    out_nxt_s = out_r;
    cnt_nxt_s = cnt_r;
    case ({req_fire_s, rsp_take_s})
      2'b10:   out_nxt_s = out_r + CNT_ONE;
      2'b01:   out_nxt_s = out_r - CNT_ONE;
      default: out_nxt_s = out_r;
    endcase
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // fetch state, prefetch FIFO and IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      out_r         <= CNT_ZERO;
      drop_r        <= CNT_ZERO;
      cnt_r         <= CNT_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_instr_r <= NOP;
      if_id_valid_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_r[i]   <= 32'h0000_0000;
        fifo_data_r[i] <= 32'h0000_0000;
      end
    end else begin
      out_r <= out_nxt_s;
      if (redirect) begin
        fetch_pc_r    <= target_pc_s;
        rsp_pc_r      <= target_pc_s;
        // everything still in flight after this cycle belongs to the old stream
        drop_r        <= out_r - (rsp_take_s ? CNT_ONE : CNT_ZERO);
        cnt_r         <= CNT_ZERO;
        rd_ptr_r      <= PTR_ZERO;
        wr_ptr_r      <= PTR_ZERO;
        if_id_valid_r <= 1'b0;
        if_id_instr_r <= NOP;
      end else begin
        cnt_r <= cnt_nxt_s;
        if (req_fire_s) fetch_pc_r <= fetch_pc_r + 32'd4;
        if (rsp_take_s && (drop_r != CNT_ZERO)) drop_r <= drop_r - CNT_ONE;
        if (rsp_live_s) rsp_pc_r <= rsp_pc_r + 32'd4;
        if (push_s) begin
          fifo_pc_r[wr_ptr_r]   <= rsp_pc_r;
          fifo_data_r[wr_ptr_r] <= imem_rsp_data;
          wr_ptr_r              <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
        if (load_s) begin
          if (!fifo_empty_s) begin
            if_id_pc_r    <= fifo_pc_r[rd_ptr_r];
            if_id_instr_r <= fifo_data_r[rd_ptr_r];
            if_id_valid_r <= 1'b1;
          end else if (rsp_live_s) begin
            if_id_pc_r    <= rsp_pc_r;
            if_id_instr_r <= imem_rsp_data;
            if_id_valid_r <= 1'b1;
          end else begin
            if_id_instr_r <= NOP;
            if_id_valid_r <= 1'b0;
          end
        end
      end
    end
  end

  assign if_id_pc    = if_id_pc_r;
  assign if_id_instr = if_id_instr_r;
  assign if_id_valid = if_id_valid_r;

`ifdef FETCH_MISALIGN_CHK_EN
  logic halted_r, misalign_r;

  // a misaligned redirect halts fetch until the next aligned redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_r   <= 1'b0;
      misalign_r <= 1'b0;
    end else if (redirect) begin
      halted_r   <= (redirect_pc[1:0] != 2'b00);
      misalign_r <= (redirect_pc[1:0] != 2'b00);
    end else begin
      misalign_r <= 1'b0;
    end
  end

  assign halted_s       = halted_r;
  assign fetch_misalign = misalign_r;
`else
  assign halted_s       = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  fetch_unit_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .full  (cnt_r == CW'(FIFO_DEPTH))
  );
endmodule
